// File: rtl/sseg_scan_capture_pkg.sv
// Shared constants for the 7-seg scan capture block: segment patterns,
// anode strobes, capture FSM states and slot decoding.
// Optional feature macro: SSEG_CAP_BLANK_EN (all-segments-off decodes as blank).
package sseg_scan_capture_pkg;

    // Active-low anode strobes, one per digit slot
    localparam logic [3:0] AN_D0 = 4'b1110;
    localparam logic [3:0] AN_D1 = 4'b1101;
    localparam logic [3:0] AN_D2 = 4'b1011;
    localparam logic [3:0] AN_D3 = 4'b0111;

    // All segments dark
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [2:0] {
        HUNT,
        HOLD,
        SETTLE,
        COMMIT,
        ABORT
    } cap_state_t;

    // Driver encoding, active low, bit6=a .. bit0=g
    function automatic logic [6:0] seg_pattern(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // Returns {valid, slot index}; anything but a single low anode is invalid
    function automatic logic [2:0] slot_of(input logic [3:0] an);
        logic [2:0] res;
        case (an)
            AN_D0:   res = 3'b100;
            AN_D1:   res = 3'b101;
            AN_D2:   res = 3'b110;
            AN_D3:   res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sseg_scan_capture_if.sv
// Scan bus (anode/segment lines) plus the captured-frame outputs.
// The slave modport is the capture block; master is the driver/consumer side.
// Optional feature macro: SSEG_CAP_BLANK_EN adds blank_mask.
interface sseg_scan_capture_if;
    logic [3:0] an_in;
    logic [7:0] sseg_in;
    logic [3:0] hex0;
    logic [3:0] hex1;
    logic [3:0] hex2;
    logic [3:0] hex3;
    logic [3:0] dp_out;
    logic       frame_valid;
    logic       frame_err;
    logic       scan_lost;
`ifdef SSEG_CAP_BLANK_EN
    logic [3:0] blank_mask;
`endif

    modport slave (
`ifdef SSEG_CAP_BLANK_EN
        output blank_mask,
`endif
        input  an_in, sseg_in,
        output hex0, hex1, hex2, hex3, dp_out, frame_valid, frame_err, scan_lost
    );

    modport master (
`ifdef SSEG_CAP_BLANK_EN
        input  blank_mask,
`endif
        output an_in, sseg_in,
        input  hex0, hex1, hex2, hex3, dp_out, frame_valid, frame_err, scan_lost
    );
endinterface

// File: rtl/sseg_scan_capture_decode.sv
// Inverse of the 7-seg driver table: segment pattern -> hex digit.
// Optional feature macro: SSEG_CAP_BLANK_EN makes all-dark a valid blank digit.
module sseg_scan_capture_decode
    import sseg_scan_capture_pkg::*;
(
    input  logic [6:0] seg,
`ifdef SSEG_CAP_BLANK_EN
    output logic       blank,
`endif
    output logic       valid,
    output logic [3:0] hex
);

    // Search the 16-entry table; no match leaves valid low
    always_comb begin
        valid = 1'b0;
        hex   = 4'h0;
`ifdef SSEG_CAP_BLANK_EN
        blank = 1'b0;
        if (seg == SEG_BLANK) begin
            valid = 1'b1;
            blank = 1'b1;
        end
`endif
        for (int i = 0; i < 16; i++) begin
            if (seg == seg_pattern(4'(i))) begin
                valid = 1'b1;
                hex   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sseg_scan_capture.sv
// Receive side of the 4-digit multiplexed 7-seg driver: synchronise the
// anode/segment lines, wait for each slot to settle, decode and assemble
// a frame, then commit it to the outputs in one step.
// Optional feature macro: SSEG_CAP_BLANK_EN (blank digits, blank_mask output).
//
// state  | meaning
// HUNT   | waiting for a settled slot 0 to start a frame
// HOLD   | slot_k sampled, waiting for the anode to move to slot_k+1
// SETTLE | anode moved to slot_k, waiting for the lines to settle
// COMMIT | frame complete, outputs load from buffer
// ABORT  | partial frame discarded, error pulse
module sseg_scan_capture
    import sseg_scan_capture_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT_W     = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    sseg_scan_capture_if.slave   bus
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    logic [3:0]           an_sync   [SYNC_STAGES];
    logic [7:0]           sseg_sync [SYNC_STAGES];
    logic [3:0]           an_s, an_p;
    logic [7:0]           sseg_s, sseg_p;
    logic                 an_chg, any_chg, settled;
    logic [SW-1:0]        settle_cnt;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic                 slot_ok;
    logic [1:0]           slot_idx;
    logic                 dec_valid;
    logic [3:0]           dec_hex;
    cap_state_t           state, next_state;
    logic [1:0]           slot_k, next_k;
    logic                 do_sample;
    logic [3:0][3:0]      buf_hex, hex_r;
    logic [3:0]           buf_dp, dp_r;
    logic                 fv_r, fe_r;
`ifdef SSEG_CAP_BLANK_EN
    logic                 dec_blank;
    logic [3:0]           buf_blank, blank_r;
`endif

    assign an_s     = an_sync[SYNC_STAGES-1];
    assign sseg_s   = sseg_sync[SYNC_STAGES-1];
    assign an_chg   = (an_s != an_p);
    assign any_chg  = an_chg || (sseg_s != sseg_p);
    // A change in the same cycle always beats settle completion
    assign settled  = !any_chg && (settle_cnt == SW'(SETTLE_CYCLES));
    assign {slot_ok, slot_idx} = slot_of(an_s);

    sseg_scan_capture_decode u_decode (
        .seg   (sseg_s[6:0]),
`ifdef SSEG_CAP_BLANK_EN
        .blank (dec_blank),
`endif
        .valid (dec_valid),
        .hex   (dec_hex)
    );

    // Input synchronisers plus one-cycle-old copy for change detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                an_sync[i]   <= 4'hF;
                sseg_sync[i] <= 8'hFF;
            end
            an_p   <= 4'hF;
            sseg_p <= 8'hFF;
        end else begin
            an_sync[0]   <= bus.an_in;
            sseg_sync[0] <= bus.sseg_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                an_sync[i]   <= an_sync[i-1];
                sseg_sync[i] <= sseg_sync[i-1];
            end
            an_p   <= an_s;
            sseg_p <= sseg_s;
        end
    end

    // Saturating settle and inactivity counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            if (any_chg)
                settle_cnt <= '0;
            else if (settle_cnt < SW'(SETTLE_CYCLES))
                settle_cnt <= settle_cnt + 1'b1;
            if (an_chg)
                to_cnt <= '0;
            else if (to_cnt != '1)
                to_cnt <= to_cnt + 1'b1;
        end
    end

    // Next-state logic; slot_k+1 wraps 3->0 so HOLD(slot 3) accepts a new frame
    always_comb begin
        next_state = state;
        next_k     = slot_k;
        do_sample  = 1'b0;
        case (state)
            HUNT: begin
                if (settled && slot_ok && slot_idx == 2'd0) begin
                    do_sample  = 1'b1;
                    next_k     = 2'd0;
                    next_state = dec_valid ? HOLD : ABORT;
                end
            end
            HOLD, COMMIT: begin
                // COMMIT also watches the anode so a fast scan is not missed
                if (an_chg) begin
                    if (slot_ok && slot_idx == 2'(slot_k + 2'd1)) begin
                        next_state = SETTLE;
                        next_k     = slot_idx;
                    end else begin
                        next_state = ABORT;
                    end
                end else if (state == COMMIT) begin
                    next_state = HOLD;
                end
            end
            SETTLE: begin
                if (an_chg) begin
                    next_state = ABORT;
                end else if (settled) begin
                    do_sample = 1'b1;
                    if (!dec_valid)
                        next_state = ABORT;
                    else if (slot_k == 2'd3)
                        next_state = COMMIT;
                    else
                        next_state = HOLD;
                end
            end
            ABORT:   next_state = HUNT;
            default: next_state = HUNT;
        endcase
    end

    // State, frame buffer and committed outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            slot_k    <= 2'd0;
            buf_hex   <= '0;
            buf_dp    <= 4'hF;
            hex_r     <= '0;
            dp_r      <= 4'hF;
            fv_r      <= 1'b0;
            fe_r      <= 1'b0;
`ifdef SSEG_CAP_BLANK_EN
            buf_blank <= 4'h0;
            blank_r   <= 4'h0;
`endif
        end else begin
            state  <= next_state;
            slot_k <= next_k;
            fv_r   <= (state == COMMIT);
            fe_r   <= (state == ABORT);
            if (state == ABORT) begin
                buf_hex   <= '0;
                buf_dp    <= 4'hF;
`ifdef SSEG_CAP_BLANK_EN
                buf_blank <= 4'h0;
`endif
            end else if (do_sample && dec_valid) begin
                buf_hex[next_k]   <= dec_hex;
                buf_dp[next_k]    <= sseg_s[7];
`ifdef SSEG_CAP_BLANK_EN
                buf_blank[next_k] <= dec_blank;
`endif
            end
            if (state == COMMIT) begin
                hex_r   <= buf_hex;
                dp_r    <= buf_dp;
`ifdef SSEG_CAP_BLANK_EN
                blank_r <= buf_blank;
`endif
            end
        end
    end

    assign bus.hex0        = hex_r[0];
    assign bus.hex1        = hex_r[1];
    assign bus.hex2        = hex_r[2];
    assign bus.hex3        = hex_r[3];
    assign bus.dp_out      = dp_r;
    assign bus.frame_valid = fv_r;
    assign bus.frame_err   = fe_r;
    assign bus.scan_lost   = (to_cnt == '1);
`ifdef SSEG_CAP_BLANK_EN
    assign bus.blank_mask  = blank_r;
`endif

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Scoreboard bench for sseg_scan_capture: stimulus pushes the expected
// frame/error event, a monitor pops and compares on each frame_valid/frame_err.
// Build with SSEG_CAP_BLANK_EN defined to exercise the blank-digit option.
module tb_sseg_scan_capture;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sseg_scan_capture_if bus();

    sseg_scan_capture #(
        .SYNC_STAGES   (2),
        .SETTLE_CYCLES (4),
        .TIMEOUT_W     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        is_err;
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] cur_hex   = 16'h0000;
    logic [3:0]  cur_dp    = 4'hF;
    logic [3:0]  cur_blank = 4'h0;

    function automatic logic [6:0] enc(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;  default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_frame(input logic [3:0] h0, input logic [3:0] h1, input logic [3:0] h2,
                                input logic [3:0] h3, input logic [3:0] dp, input logic [3:0] bl);
        exp_t e;
        e.is_err = 1'b0;
        e.hex    = {h3, h2, h1, h0};
        e.dp     = dp;
        e.blank  = bl;
        sb_q.push_back(e);
        cur_hex   = e.hex;
        cur_dp    = dp;
        cur_blank = bl;
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.hex    = cur_hex;
        e.dp     = cur_dp;
        e.blank  = cur_blank;
        sb_q.push_back(e);
    endtask

    task automatic drive(input int idx, input logic [6:0] seg, input logic dp, input int n);
        logic [3:0] one;
        one = 4'b0001 << idx;
        bus.an_in   = ~one;
        bus.sseg_in = {dp, seg};
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic [3:0] dp);
        drive(0, s0, dp[0], 64);
        drive(1, s1, dp[1], 64);
        drive(2, s2, dp[2], 64);
        drive(3, s3, dp[3], 64);
    endtask

    // Monitor: every frame event must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && (bus.frame_valid || bus.frame_err)) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: valid=%b err=%b with empty scoreboard at %0t",
                         bus.frame_valid, bus.frame_err, $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("event_kind", {30'd0, bus.frame_valid, bus.frame_err},
                      mon_e.is_err ? 32'd1 : 32'd2);
                check("frame_hex", {16'd0, bus.hex3, bus.hex2, bus.hex1, bus.hex0}, {16'd0, mon_e.hex});
                check("frame_dp", {28'd0, bus.dp_out}, {28'd0, mon_e.dp});
`ifdef SSEG_CAP_BLANK_EN
                check("frame_blank", {28'd0, bus.blank_mask}, {28'd0, mon_e.blank});
`endif
            end
        end
    end

    initial begin
        bus.an_in   = 4'hF;
        bus.sseg_in = 8'hFF;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_hex", {16'd0, bus.hex3, bus.hex2, bus.hex1, bus.hex0}, 32'h0);
        check("rst_dp", {28'd0, bus.dp_out}, 32'hF);
        check("rst_valid", {31'd0, bus.frame_valid}, 32'd0);
        check("rst_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_lost", {31'd0, bus.scan_lost}, 32'd0);
`ifdef SSEG_CAP_BLANK_EN
        check("rst_blank", {28'd0, bus.blank_mask}, 32'd0);
`endif
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Basic frame 3,0,0,7 with mixed decimal points
        expect_frame(4'h3, 4'h0, 4'h0, 4'h7, 4'b1011, 4'h0);
        frame(enc(4'h3), enc(4'h0), enc(4'h0), enc(4'h7), 4'b1011);

        // Undecodable slot 1 aborts, then a clean frame commits
        expect_err();
        drive(0, enc(4'h5), 1'b1, 64);
        drive(1, 7'b1111110, 1'b1, 64);
        expect_frame(4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 4'h0);
        frame(enc(4'h1), enc(4'h2), enc(4'h3), enc(4'h4), 4'hF);

        // Skipped slot, then a two-low anode pattern
        expect_err();
        drive(0, enc(4'h8), 1'b1, 64);
        drive(2, enc(4'h8), 1'b1, 64);
        expect_err();
        drive(0, enc(4'h8), 1'b1, 64);
        bus.an_in = 4'b1100;
        repeat (64) @(negedge clk);

        // Segment glitching on slot 1 must not be sampled
        expect_frame(4'h9, 4'h6, 4'hA, 4'hF, 4'b0110, 4'h0);
        drive(0, enc(4'h9), 1'b0, 64);
        for (int i = 0; i < 10; i++)
            drive(1, (i % 2 == 1) ? enc(4'h1) : enc(4'h8), 1'b1, 2);
        drive(1, enc(4'h6), 1'b1, 64);
        drive(2, enc(4'hA), 1'b1, 64);
        drive(3, enc(4'hF), 1'b0, 64);

        // Frozen anode: inactivity timeout (255 cycles with TIMEOUT_W=8)
        repeat (100) @(negedge clk);
        check("lost_early", {31'd0, bus.scan_lost}, 32'd0);
        repeat (200) @(negedge clk);
        check("lost_set", {31'd0, bus.scan_lost}, 32'd1);
        expect_frame(4'h2, 4'h4, 4'h6, 4'h8, 4'hF, 4'h0);
        bus.an_in   = 4'b1110;
        bus.sseg_in = {1'b1, enc(4'h2)};
        repeat (2) @(negedge clk);
        check("lost_hold", {31'd0, bus.scan_lost}, 32'd1);
        @(negedge clk);
        check("lost_clear", {31'd0, bus.scan_lost}, 32'd0);
        repeat (61) @(negedge clk);
        drive(1, enc(4'h4), 1'b1, 64);
        drive(2, enc(4'h6), 1'b1, 64);
        drive(3, enc(4'h8), 1'b1, 64);

        // Reset in the middle of slot 2 discards the partial frame
        drive(0, enc(4'h1), 1'b1, 64);
        drive(1, enc(4'h5), 1'b1, 64);
        drive(2, enc(4'h9), 1'b1, 10);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        cur_hex   = 16'h0000;
        cur_dp    = 4'hF;
        cur_blank = 4'h0;
        check("midrst_hex", {16'd0, bus.hex3, bus.hex2, bus.hex1, bus.hex0}, 32'h0);
        check("midrst_dp", {28'd0, bus.dp_out}, 32'hF);
        check("midrst_lost", {31'd0, bus.scan_lost}, 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        expect_frame(4'h1, 4'h5, 4'h9, 4'hB, 4'b1010, 4'h0);
        frame(enc(4'h1), enc(4'h5), enc(4'h9), enc(4'hB), 4'b1010);

        // All-dark slot 3
`ifdef SSEG_CAP_BLANK_EN
        expect_frame(4'h5, 4'h5, 4'h5, 4'h0, 4'hF, 4'b1000);
`else
        expect_err();
`endif
        frame(enc(4'h5), enc(4'h5), enc(4'h5), 7'b1111111, 4'hF);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
